// File: rtl/mem_arbiter.sv
// Shares the single main-memory read/write channel pair between the I-cache refill port and the
// D-cache refill/write-through port, one outstanding transaction at a time, round-robin I vs D.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int CACHE_LINE_WIDTH = 256
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,

    input  logic                        i_ic_req,
    input  logic [ADDR_WIDTH-1:0]       i_ic_addr,
    output logic                        o_ic_done,
    output logic [CACHE_LINE_WIDTH-1:0] o_ic_line,

    input  logic                        i_dc_rd_req,
    input  logic [ADDR_WIDTH-1:0]       i_dc_rd_addr,
    output logic                        o_dc_rd_done,
    output logic [CACHE_LINE_WIDTH-1:0] o_dc_line,

    input  logic                        i_dc_wr_req,
    input  logic [ADDR_WIDTH-1:0]       i_dc_wr_addr,
    input  logic [DATA_WIDTH-1:0]       i_dc_wr_data,
    input  logic [3:0]                  i_dc_wr_strb,
    output logic                        o_dc_wr_done,

    output logic [ADDR_WIDTH-1:0]       o_mem_read_address,
    output logic                        o_mem_read_req,
    input  logic                        i_mem_read_done,
    input  logic [CACHE_LINE_WIDTH-1:0] i_cache_line,

    output logic                        o_mem_write_valid,
    output logic [ADDR_WIDTH-1:0]       o_mem_write_address,
    output logic [DATA_WIDTH-1:0]       o_mem_write_data,
    output logic [7:0]                  o_write_strobe,
    input  logic                        i_mem_write_done,

    output logic                        o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    typedef enum logic [1:0] {
        CL_IC,
        CL_DC_RD,
        CL_DC_WR
    } client_e;

    state_e                  state;
    client_e                 cur_client;
    logic                    rr_last_dc;

    logic                    ic_pend;
    logic                    dc_pend;
    logic                    any_pend;
    logic                    grant_dc;
    client_e                 grant_client;
    logic [ADDR_WIDTH-1:0]   grant_rd_addr;

    always_comb begin
        ic_pend  = i_ic_req;
        dc_pend  = i_dc_wr_req | i_dc_rd_req;
        any_pend = ic_pend | dc_pend;
        // Under contention the side not granted last time wins; a lone request wins outright.
        grant_dc = dc_pend && (!ic_pend || !rr_last_dc);

        if (!grant_dc) begin
            grant_client = CL_IC;
        end else if (i_dc_wr_req) begin
            grant_client = CL_DC_WR;   // write-through must reach memory before a refill
        end else begin
            grant_client = CL_DC_RD;
        end

        grant_rd_addr = grant_dc ? i_dc_rd_addr : i_ic_addr;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state               <= S_IDLE;
            cur_client          <= CL_IC;
            rr_last_dc          <= 1'b1;
            o_ic_done           <= 1'b0;
            o_dc_rd_done        <= 1'b0;
            o_dc_wr_done        <= 1'b0;
            // NOTE: the line registers are wide but are visible outputs, so they are cleared too.
            o_ic_line           <= '0;
            o_dc_line           <= '0;
            o_mem_read_address  <= '0;
            o_mem_read_req      <= 1'b0;
            o_mem_write_valid   <= 1'b0;
            o_mem_write_address <= '0;
            o_mem_write_data    <= '0;
            o_write_strobe      <= '0;
            o_busy              <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each cycle; only the state that owns a pulse raises it.
            o_mem_read_req    <= 1'b0;
            o_mem_write_valid <= 1'b0;
            o_ic_done         <= 1'b0;
            o_dc_rd_done      <= 1'b0;
            o_dc_wr_done      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (any_pend) begin
                        cur_client <= grant_client;
                        rr_last_dc <= grant_dc;
                        o_busy     <= 1'b1;
                        state      <= S_ISSUE;
                        if (grant_client == CL_DC_WR) begin
                            o_mem_write_address <= i_dc_wr_addr;
                            o_mem_write_data    <= i_dc_wr_data;
                            o_write_strobe      <= {4'b0000, i_dc_wr_strb};
                            o_mem_write_valid   <= 1'b1;
                        end else begin
                            o_mem_read_address  <= grant_rd_addr;
                            o_mem_read_req      <= 1'b1;
                        end
                    end
                end

                // Done from memory in the pulse cycle is deliberately not looked at here.
                S_ISSUE: begin
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (cur_client == CL_DC_WR) begin
                        if (i_mem_write_done) begin
                            o_dc_wr_done <= 1'b1;
                            state        <= S_RESP;
                        end
                    end else if (i_mem_read_done) begin
                        if (cur_client == CL_IC) begin
                            o_ic_line <= i_cache_line;
                            o_ic_done <= 1'b1;
                        end else begin
                            o_dc_line    <= i_cache_line;
                            o_dc_rd_done <= 1'b1;
                        end
                        state <= S_RESP;
                    end
                end

                S_RESP: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end

                default: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then random traffic, all checked
// cycle by cycle against a transaction-timeline reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int CLW = 256;

    typedef enum int {C_NONE = 0, C_I = 1, C_DR = 2, C_DW = 3} client_e;

    logic           i_clk = 1'b0;
    logic           i_rst_n = 1'b1;
    logic           i_ic_req, i_dc_rd_req, i_dc_wr_req;
    logic [AW-1:0]  i_ic_addr, i_dc_rd_addr, i_dc_wr_addr;
    logic [DW-1:0]  i_dc_wr_data;
    logic [3:0]     i_dc_wr_strb;
    logic           i_mem_read_done, i_mem_write_done;
    logic [CLW-1:0] i_cache_line;
    logic           o_ic_done, o_dc_rd_done, o_dc_wr_done;
    logic [CLW-1:0] o_ic_line, o_dc_line;
    logic [AW-1:0]  o_mem_read_address, o_mem_write_address;
    logic           o_mem_read_req, o_mem_write_valid, o_busy;
    logic [DW-1:0]  o_mem_write_data;
    logic [7:0]     o_write_strobe;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CACHE_LINE_WIDTH(CLW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_ic_req(i_ic_req), .i_ic_addr(i_ic_addr), .o_ic_done(o_ic_done), .o_ic_line(o_ic_line),
        .i_dc_rd_req(i_dc_rd_req), .i_dc_rd_addr(i_dc_rd_addr), .o_dc_rd_done(o_dc_rd_done),
        .o_dc_line(o_dc_line),
        .i_dc_wr_req(i_dc_wr_req), .i_dc_wr_addr(i_dc_wr_addr), .i_dc_wr_data(i_dc_wr_data),
        .i_dc_wr_strb(i_dc_wr_strb), .o_dc_wr_done(o_dc_wr_done),
        .o_mem_read_address(o_mem_read_address), .o_mem_read_req(o_mem_read_req),
        .i_mem_read_done(i_mem_read_done), .i_cache_line(i_cache_line),
        .o_mem_write_valid(o_mem_write_valid), .o_mem_write_address(o_mem_write_address),
        .o_mem_write_data(o_mem_write_data), .o_write_strobe(o_write_strobe),
        .i_mem_write_done(i_mem_write_done), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: one transaction timeline (issue cycle, response cycle) plus round-robin memory.
    bit             active;
    client_e        t_client;
    logic [AW-1:0]  t_addr;
    logic [DW-1:0]  t_data;
    logic [3:0]     t_strb;
    int             issue_cyc, resp_cyc;
    bit             rr_last_d;
    logic [CLW-1:0] exp_ic_line, exp_dc_line;

    // Stimulus controls for clients and the memory responder.
    int             ic_todo, dr_todo, dw_todo;
    bit             rand_mode;
    int unsigned    raise_pct;
    logic [AW-1:0]  ic_addr_dir, dr_addr_dir, dw_addr_dir;
    logic [DW-1:0]  dw_data_dir;
    logic [3:0]     dw_strb_dir;
    int             mem_delay;
    bit             stray;
    bit             line_rand;
    logic [CLW-1:0] line_dir, pend_line;
    int             rd_cnt, wr_cnt;

    // Observations taken from the DUT outputs.
    int             n_rreq, n_wval, n_icd, n_drd, n_dwd;
    int             ic_raise_cyc, icd_cyc;
    logic [7:0]     wv_strobe;
    client_e        obs_log[$];
    client_e        exp_seq[6];

    task automatic check(input string tag, input logic [CLW-1:0] obs, input logic [CLW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CLW-1:0] rand_line();
        logic [CLW-1:0] l;
        for (int k = 0; k < CLW / 32; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic clear_tallies();
        n_rreq = 0; n_wval = 0; n_icd = 0; n_drd = 0; n_dwd = 0;
        icd_cyc = -1; ic_raise_cyc = -1; wv_strobe = '0;
        obs_log.delete();
    endtask

    task automatic mem_react();
        bit stray_now;
        stray_now = rand_mode ? 1'($urandom_range(0, 1)) : stray;
        i_cache_line     = rand_line();
        i_mem_read_done  = 1'b0;
        i_mem_write_done = 1'b0;
        if (o_mem_read_req) begin
            rd_cnt          = rand_mode ? int'($urandom_range(1, 6)) : mem_delay;
            pend_line       = line_rand ? rand_line() : line_dir;
            i_mem_read_done = stray_now;
        end else if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                i_mem_read_done = 1'b1;
                i_cache_line    = pend_line;
            end
        end
        if (o_mem_write_valid) begin
            wr_cnt           = rand_mode ? int'($urandom_range(1, 6)) : mem_delay;
            i_mem_write_done = stray_now;
        end else if (wr_cnt > 0) begin
            wr_cnt--;
            if (wr_cnt == 0) i_mem_write_done = 1'b1;
        end
    endtask

    task automatic raise_reqs(input bit drop_i, input bit drop_r, input bit drop_w);
        if (!i_ic_req && !drop_i && ic_todo > 0 && $urandom_range(0, 99) < raise_pct) begin
            i_ic_req = 1'b1;
            i_ic_addr = rand_mode ? $urandom : ic_addr_dir;
            ic_todo--;
            ic_raise_cyc = cyc;
        end
        if (!i_dc_rd_req && !drop_r && dr_todo > 0 && $urandom_range(0, 99) < raise_pct) begin
            i_dc_rd_req = 1'b1;
            i_dc_rd_addr = rand_mode ? $urandom : dr_addr_dir;
            dr_todo--;
        end
        if (!i_dc_wr_req && !drop_w && dw_todo > 0 && $urandom_range(0, 99) < raise_pct) begin
            i_dc_wr_req  = 1'b1;
            i_dc_wr_addr = rand_mode ? $urandom : dw_addr_dir;
            i_dc_wr_data = rand_mode ? $urandom : dw_data_dir;
            i_dc_wr_strb = rand_mode ? 4'($urandom_range(0, 15)) : dw_strb_dir;
            dw_todo--;
        end
    endtask

    // Advances the model past the current cycle using the inputs the bench is now driving.
    task automatic model_update();
        bit ipend, dpend, pick_d;
        ipend = i_ic_req;
        dpend = i_dc_rd_req || i_dc_wr_req;
        if (active) begin
            if (cyc == resp_cyc) begin
                active = 1'b0;
            end else if (resp_cyc < 0 && cyc > issue_cyc &&
                         ((t_client == C_DW) ? i_mem_write_done : i_mem_read_done)) begin
                resp_cyc = cyc + 1;
                if (t_client == C_I)  exp_ic_line = i_cache_line;
                if (t_client == C_DR) exp_dc_line = i_cache_line;
            end
        end else if (ipend || dpend) begin
            if (ipend && dpend) pick_d = !rr_last_d;
            else                pick_d = dpend;
            rr_last_d = pick_d;
            if (!pick_d) begin
                t_client = C_I;
                t_addr   = i_ic_addr;
            end else if (i_dc_wr_req) begin
                t_client = C_DW;
                t_addr   = i_dc_wr_addr;
                t_data   = i_dc_wr_data;
                t_strb   = i_dc_wr_strb;
            end else begin
                t_client = C_DR;
                t_addr   = i_dc_rd_addr;
            end
            active    = 1'b1;
            issue_cyc = cyc + 1;
            resp_cyc  = -1;
        end
    endtask

    task automatic step();
        bit drop_i, drop_r, drop_w, is_rd;
        drop_i = 1'b0; drop_r = 1'b0; drop_w = 1'b0;
        @(negedge i_clk);
        cyc++;
        is_rd = (t_client != C_DW);
        check("busy", CLW'(o_busy), CLW'(active));
        check("mem_read_req", CLW'(o_mem_read_req), CLW'(active && cyc == issue_cyc && is_rd));
        check("mem_write_valid", CLW'(o_mem_write_valid), CLW'(active && cyc == issue_cyc && !is_rd));
        check("ic_done", CLW'(o_ic_done), CLW'(active && cyc == resp_cyc && t_client == C_I));
        check("dc_rd_done", CLW'(o_dc_rd_done), CLW'(active && cyc == resp_cyc && t_client == C_DR));
        check("dc_wr_done", CLW'(o_dc_wr_done), CLW'(active && cyc == resp_cyc && t_client == C_DW));
        check("ic_line", o_ic_line, exp_ic_line);
        check("dc_line", o_dc_line, exp_dc_line);
        if (active && is_rd) check("read_address", CLW'(o_mem_read_address), CLW'(t_addr));
        if (active && !is_rd) begin
            check("write_address", CLW'(o_mem_write_address), CLW'(t_addr));
            check("write_data", CLW'(o_mem_write_data), CLW'(t_data));
            check("write_strobe", CLW'(o_write_strobe), CLW'({4'b0000, t_strb}));
        end

        if (o_mem_read_req) n_rreq++;
        if (o_mem_write_valid) begin
            n_wval++;
            wv_strobe = o_write_strobe;
        end
        if (o_ic_done) begin
            n_icd++; icd_cyc = cyc; obs_log.push_back(C_I);
            i_ic_req = 1'b0; drop_i = 1'b1;
        end
        if (o_dc_rd_done) begin
            n_drd++; obs_log.push_back(C_DR);
            i_dc_rd_req = 1'b0; drop_r = 1'b1;
        end
        if (o_dc_wr_done) begin
            n_dwd++; obs_log.push_back(C_DW);
            i_dc_wr_req = 1'b0; drop_w = 1'b1;
        end

        mem_react();
        raise_reqs(drop_i, drop_r, drop_w);
        model_update();
    endtask

    task automatic run_until_quiet(input int budget, input string tag);
        int  n;
        bit  quiet;
        n = 0;
        do begin
            step();
            n++;
            quiet = (ic_todo + dr_todo + dw_todo == 0) && !i_ic_req && !i_dc_rd_req &&
                    !i_dc_wr_req && !active;
        end while (!quiet && n < budget);
        check({tag, "_within_budget"}, CLW'(quiet), CLW'(1'b1));
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        cyc++;
        i_rst_n = 1'b0;
        i_ic_req = 1'b0; i_dc_rd_req = 1'b0; i_dc_wr_req = 1'b0;
        i_mem_read_done = 1'b0; i_mem_write_done = 1'b0;
        rd_cnt = 0; wr_cnt = 0;
        ic_todo = 0; dr_todo = 0; dw_todo = 0;
        #1;
        check("rst_busy", CLW'(o_busy), '0);
        check("rst_ic_done", CLW'(o_ic_done), '0);
        check("rst_dc_rd_done", CLW'(o_dc_rd_done), '0);
        check("rst_dc_wr_done", CLW'(o_dc_wr_done), '0);
        check("rst_ic_line", o_ic_line, '0);
        check("rst_dc_line", o_dc_line, '0);
        check("rst_read_req", CLW'(o_mem_read_req), '0);
        check("rst_read_address", CLW'(o_mem_read_address), '0);
        check("rst_write_valid", CLW'(o_mem_write_valid), '0);
        check("rst_write_address", CLW'(o_mem_write_address), '0);
        check("rst_write_data", CLW'(o_mem_write_data), '0);
        check("rst_write_strobe", CLW'(o_write_strobe), '0);
        active = 1'b0; resp_cyc = -1; issue_cyc = -1; rr_last_d = 1'b1;
        exp_ic_line = '0; exp_dc_line = '0;
        @(negedge i_clk);
        cyc++;
        i_rst_n = 1'b1;
    endtask

    initial begin
        i_ic_req = 1'b0; i_dc_rd_req = 1'b0; i_dc_wr_req = 1'b0;
        i_ic_addr = '0; i_dc_rd_addr = '0; i_dc_wr_addr = '0;
        i_dc_wr_data = '0; i_dc_wr_strb = '0;
        i_mem_read_done = 1'b0; i_mem_write_done = 1'b0; i_cache_line = '0;
        active = 1'b0; t_client = C_NONE; t_addr = '0; t_data = '0; t_strb = '0;
        issue_cyc = -1; resp_cyc = -1; rr_last_d = 1'b1;
        exp_ic_line = '0; exp_dc_line = '0;
        rand_mode = 1'b0; raise_pct = 100; mem_delay = 1; stray = 1'b0;
        line_rand = 1'b1; line_dir = '0; pend_line = '0;
        ic_addr_dir = '0; dr_addr_dir = '0; dw_addr_dir = '0; dw_data_dir = '0; dw_strb_dir = '0;
        clear_tallies();

        do_reset();

        // Reset while an I-side read is stuck in WAIT: it must vanish without a done.
        ic_addr_dir = 32'h0000_0080; mem_delay = 10; ic_todo = 1;
        repeat (5) step();
        check("t1_busy_before_reset", CLW'(o_busy), CLW'(1'b1));
        do_reset();
        clear_tallies();
        repeat (12) step();
        check("t1_no_ic_done", CLW'(n_icd), '0);
        check("t1_no_reissue", CLW'(n_rreq), '0);

        // Single I-cache refill with 1-cycle memory.
        clear_tallies();
        ic_addr_dir = 32'h0000_0040; mem_delay = 1;
        line_rand = 1'b0; line_dir = {8{32'hA5A5_0001}};
        ic_todo = 1;
        run_until_quiet(50, "t2");
        line_rand = 1'b1;
        check("t2_read_pulses", CLW'(n_rreq), CLW'(1));
        check("t2_ic_done_count", CLW'(n_icd), CLW'(1));
        check("t2_latency", CLW'(icd_cyc - ic_raise_cyc), CLW'(3));
        check("t2_ic_line", o_ic_line, {8{32'hA5A5_0001}});

        // D-cache write-through.
        clear_tallies();
        dw_addr_dir = 32'h0000_0100; dw_data_dir = 32'hDEAD_BEEF; dw_strb_dir = 4'b0011;
        dw_todo = 1;
        run_until_quiet(50, "t3");
        check("t3_write_pulses", CLW'(n_wval), CLW'(1));
        check("t3_wr_done_count", CLW'(n_dwd), CLW'(1));
        check("t3_strobe", CLW'(wv_strobe), CLW'(8'h03));
        check("t3_no_read", CLW'(n_rreq), '0);

        // I and D-read contending from reset: strict alternation starting with I.
        do_reset();
        clear_tallies();
        ic_addr_dir = 32'h0000_0400; dr_addr_dir = 32'h0000_0800;
        ic_todo = 3; dr_todo = 3;
        run_until_quiet(200, "t4");
        exp_seq = '{C_I, C_DR, C_I, C_DR, C_I, C_DR};
        check("t4_rounds", CLW'(obs_log.size()), CLW'(6));
        for (int i = 0; i < 6; i++) begin
            if (i < obs_log.size()) check($sformatf("t4_order%0d", i), CLW'(obs_log[i]), CLW'(exp_seq[i]));
        end

        // D-side read and write together: write first.
        clear_tallies();
        dr_addr_dir = 32'h0000_0200; dw_addr_dir = 32'h0000_0200;
        dw_data_dir = 32'h1234_5678; dw_strb_dir = 4'b1111;
        dr_todo = 1; dw_todo = 1;
        run_until_quiet(100, "t5");
        check("t5_count", CLW'(obs_log.size()), CLW'(2));
        if (obs_log.size() > 0) check("t5_first", CLW'(obs_log[0]), CLW'(C_DW));
        if (obs_log.size() > 1) check("t5_second", CLW'(obs_log[1]), CLW'(C_DR));
        check("t5_wr_done_count", CLW'(n_dwd), CLW'(1));
        check("t5_rd_done_count", CLW'(n_drd), CLW'(1));

        // Slow memory with a stray done during the issue cycle.
        clear_tallies();
        ic_addr_dir = 32'h0000_00C0; mem_delay = 5; stray = 1'b1;
        ic_todo = 1;
        run_until_quiet(100, "t6");
        stray = 1'b0; mem_delay = 1;
        check("t6_read_pulses", CLW'(n_rreq), CLW'(1));
        check("t6_ic_done_count", CLW'(n_icd), CLW'(1));
        check("t6_latency", CLW'(icd_cyc - ic_raise_cyc), CLW'(7));

        // Random traffic from all three clients, random memory delay and stray dones.
        clear_tallies();
        rand_mode = 1'b1; raise_pct = 30;
        ic_todo = 15; dr_todo = 15; dw_todo = 15;
        run_until_quiet(4000, "rand");
        check("rand_ic_done_count", CLW'(n_icd), CLW'(15));
        check("rand_dc_rd_done_count", CLW'(n_drd), CLW'(15));
        check("rand_dc_wr_done_count", CLW'(n_dwd), CLW'(15));
        check("rand_read_pulses", CLW'(n_rreq), CLW'(30));
        check("rand_write_pulses", CLW'(n_wval), CLW'(15));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
